// File: rtl/lab4_io_pkg.sv
// Shared constants for the lab4 I/O conditioning stage: button/switch field map
// and the short debounce length used in simulation.
package lab4_io_pkg;

  localparam int BTN_LOADA    = 0;
  localparam int BTN_LOADB    = 1;
  localparam int BTN_EXEC     = 2;

  localparam int DIN_LSB      = 0;
  localparam int F_LSB        = 8;
  localparam int R_LSB        = 11;

  localparam int DEBOUNCE_SIM = 4;

  // Counter width able to hold 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One active-low button: 2-flop synchroniser, stability counter, accepted level
// and registered one-cycle press/release pulses.
module debounce_channel
  import lab4_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_n,
  output logic btn_n,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample equal to the accepted level restarts the count, so bounces are dropped.
  always_comb begin
    cnt_d     = '0;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_TERM) begin
        stable_d  = sync2_q;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw_n;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_n         = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Input conditioning ahead of the logic processor: debounced active-low buttons
// with press/release pulses, plus plain 2-flop synchronised slide switches.
module button_conditioner
  import lab4_io_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int SW_W            = 13,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  input  logic [SW_W-1:0]    sw_raw,
  output logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [SW_W-1:0]    sw_sync
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .btn_raw_n    (btn_raw_n[i]),
      .btn_n        (btn_n[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

  // Switches are only read as static levels, so synchronising without debounce is enough.
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_raw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_sync = sw_sync_q;

endmodule
